// File: rtl/cim_sum_reducer.sv
// Compute-in-memory column-sum reducer: folds per-pass 4x18-bit block sums into
// a 40-bit two's-complement dot product using a bit-serial shift-accumulate.
module cim_sum_reducer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  num_passes,
    input  logic        signed_in,
    input  logic        sum_valid,
    input  logic [71:0] sum,
    input  logic        result_ready,
    output logic [39:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        overrun
);
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

    state_t      state;
    logic [2:0]  p;
    logic [2:0]  p_last;
    logic        signed_q;
    logic [39:0] acc;

    // Stage-1 pipeline register: one consumed pass waiting to be accumulated
    logic        stg1_vld;
    logic [30:0] comb_q;
    logic [2:0]  p_q;
    logic        last_q;

    logic [30:0] comb_d;
    logic [39:0] addend;
    logic [39:0] acc_next;

    assign comb_d = 31'(sum[17:0])
                  + (31'(sum[35:18]) << 4)
                  + (31'(sum[53:36]) << 8)
                  + (31'(sum[71:54]) << 12);

    always_comb begin
        addend   = 40'(comb_q) << p_q;
        acc_next = acc;
        if (stg1_vld) begin
            // MSB pass of a two's-complement input carries negative weight
            if (last_q && signed_q)
                acc_next = acc - addend;
            else
                acc_next = acc + addend;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            p            <= '0;
            p_last       <= '0;
            signed_q     <= 1'b0;
            acc          <= '0;
            stg1_vld     <= 1'b0;
            comb_q       <= '0;
            p_q          <= '0;
            last_q       <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            stg1_vld <= 1'b0;
            acc      <= acc_next;
            if (sum_valid && state != ACCUM)
                overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (start) begin
                        p_last   <= num_passes - 3'd1;
                        signed_q <= signed_in;
                        acc      <= '0;
                        p        <= '0;
                        busy     <= 1'b1;
                        state    <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (sum_valid) begin
                        comb_q   <= comb_d;
                        p_q      <= p;
                        last_q   <= (p == p_last);
                        stg1_vld <= 1'b1;
                        p        <= p + 3'd1;
                        if (p == p_last)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    result       <= acc_next;
                    result_valid <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (result_ready) begin
                        result       <= '0;
                        result_valid <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cim_sum_reducer.sv
// Directed bench for cim_sum_reducer: integer-arithmetic reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_cim_sum_reducer;
    logic        clk = 1'b0;
    logic        reset, start, signed_in, sum_valid, result_ready;
    logic [2:0]  num_passes;
    logic [71:0] sum;
    logic [39:0] result;
    logic        result_valid, busy, overrun;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    cim_sum_reducer dut (
        .clk(clk), .reset(reset), .start(start), .num_passes(num_passes),
        .signed_in(signed_in), .sum_valid(sum_valid), .sum(sum),
        .result_ready(result_ready), .result(result), .result_valid(result_valid),
        .busy(busy), .overrun(overrun)
    );

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: operation-level bookkeeping with plain integer math
    typedef enum {M_IDLE, M_ACC, M_WAIT, M_DONE} mmode_t;
    mmode_t m_mode = M_IDLE;
    longint m_total = 0;
    int     m_n = 1, m_k = 0;
    bit     m_sgn = 1'b0, m_ovr = 1'b0;

    always @(posedge clk) begin
        longint c, term;
        if (reset) begin
            m_mode = M_IDLE; m_total = 0; m_k = 0; m_ovr = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (sum_valid) m_ovr = 1'b1;
                    if (start) begin
                        m_mode  = M_ACC;
                        m_n     = (num_passes == 3'd0) ? 8 : int'(num_passes);
                        m_sgn   = signed_in;
                        m_total = 0;
                        m_k     = 0;
                    end
                end
                M_ACC: if (sum_valid) begin
                    c = longint'(sum[17:0]) + longint'(sum[35:18]) * 16
                      + longint'(sum[53:36]) * 256 + longint'(sum[71:54]) * 4096;
                    term = c * (longint'(1) << m_k);
                    if (m_k == m_n - 1 && m_sgn) m_total = m_total - term;
                    else                         m_total = m_total + term;
                    m_k++;
                    if (m_k == m_n) m_mode = M_WAIT;
                end
                M_WAIT: begin
                    if (sum_valid) m_ovr = 1'b1;
                    m_mode = M_DONE;
                end
                M_DONE: begin
                    if (sum_valid) m_ovr = 1'b1;
                    if (result_ready) m_mode = M_IDLE;
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [39:0] exp_res;
        if (chk_en) begin
            exp_res = (m_mode == M_DONE) ? m_total[39:0] : 40'd0;
            check("mdl_result_valid", 64'(result_valid), 64'(m_mode == M_DONE));
            check("mdl_result", 64'(result), 64'(exp_res));
            check("mdl_busy", 64'(busy), 64'(m_mode != M_IDLE));
            check("mdl_overrun", 64'(overrun), 64'(m_ovr));
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic go(logic [2:0] n, logic sg);
        start = 1'b1; num_passes = n; signed_in = sg;
        step();
        start = 1'b0;
    endtask

    task automatic pass(logic [17:0] s0, logic [17:0] s1, logic [17:0] s2,
                        logic [17:0] s3, int gap);
        sum_valid = 1'b1; sum = {s3, s2, s1, s0};
        step();
        sum_valid = 1'b0; sum = '0;
        repeat (gap) step();
    endtask

    task automatic wait_result(string name, logic [39:0] exp, bit release_it);
        int i = 0;
        while (!result_valid && i < 50) begin
            step();
            i++;
        end
        if (!result_valid) begin
            vectors++; miscompares++;
            $display("FAIL %s: got no result_valid expected result %0h", name, exp);
        end else begin
            check(name, 64'(result), 64'(exp));
        end
        if (release_it) begin
            result_ready = 1'b1;
            step();
            result_ready = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_passes = '0; signed_in = 1'b0;
        sum_valid = 1'b0; sum = '0; result_ready = 1'b0;
        step();
        chk_en = 1'b1;
        step();
        check("rst_result", 64'(result), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        step();

        // One pass of all-ones: 1+16+256+4096, valid two cycles after sum_valid
        go(3'd1, 1'b0);
        pass(18'd1, 18'd1, 18'd1, 18'd1, 0);
        check("lat_t1_valid", 64'(result_valid), 64'd0);
        step();
        check("lat_t2_valid", 64'(result_valid), 64'd1);
        wait_result("s1_4369", 40'd4369, 1'b1);

        // Two unsigned passes of 3: 3 + 6
        go(3'd2, 1'b0);
        pass(18'd3, 18'd0, 18'd0, 18'd0, 0);
        pass(18'd3, 18'd0, 18'd0, 18'd0, 0);
        wait_result("s2_9", 40'd9, 1'b1);

        // Two signed passes of 1: 1 - 2
        go(3'd2, 1'b1);
        pass(18'd1, 18'd0, 18'd0, 18'd0, 2);
        pass(18'd1, 18'd0, 18'd0, 18'd0, 0);
        wait_result("s3_minus1", 40'hFF_FFFF_FFFF, 1'b1);

        // Unsigned worst case, gapped 1-on/1-off
        go(3'd0, 1'b0);
        for (int i = 0; i < 8; i++) pass(18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 18'h3FFFF, 1);
        wait_result("s4_worst", 40'd292052205585, 1'b1);

        // Hold in DONE, stray sum_valid, then release with an ignored start
        go(3'd1, 1'b0);
        pass(18'd7, 18'd0, 18'd0, 18'd0, 0);
        wait_result("s5_first", 40'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("s5_hold_result", 64'(result), 64'd7);
        end
        pass(18'd9, 18'd9, 18'd9, 18'd9, 0);
        check("s5_overrun", 64'(overrun), 64'd1);
        check("s5_still_7", 64'(result), 64'd7);
        result_ready = 1'b1; start = 1'b1; num_passes = 3'd1;
        step();
        result_ready = 1'b0; start = 1'b0;
        check("s5_drop_valid", 64'(result_valid), 64'd0);
        check("s5_start_ignored", 64'(busy), 64'd0);
        step();

        // Reset mid-ACCUM after pass 3 of 8
        go(3'd0, 1'b0);
        for (int i = 0; i < 3; i++) pass(18'd100, 18'd2, 18'd3, 18'd4, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s6_rst_busy", 64'(busy), 64'd0);
        check("s6_rst_valid", 64'(result_valid), 64'd0);
        check("s6_rst_result", 64'(result), 64'd0);
        check("s6_rst_overrun", 64'(overrun), 64'd0);
        // start with a simultaneous sum: start taken, sum dropped, overrun set
        sum_valid = 1'b1; sum = {54'd0, 18'd99};
        go(3'd1, 1'b0);
        sum_valid = 1'b0; sum = '0;
        check("s6_overrun_same_cycle", 64'(overrun), 64'd1);
        pass(18'd5, 18'd0, 18'd0, 18'd0, 0);
        wait_result("s6_clean_5", 40'd5, 1'b1);
        step();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cim_sum_reducer.md
CIM_SUM_REDUCER -- requirements
Module: cim_sum_reducer

Interface
REQ-001 SHALL have exactly one clock and one reset: the clock is clk, and the reset is synchronous and active-high.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; clears all state.
REQ-004 start  input  1  begin an operation; sampled only in IDLE.
REQ-005 num_passes  input  3  input bit-width; 1..7 means 1..7 passes, 0 means 8; latched on an accepted start.
REQ-006 signed_in  input  1  1 = MSB pass carries negative weight (two's-complement input); latched on an accepted start.
REQ-007 sum_valid  input  1  sum holds one pass of column sums this cycle.
REQ-008 sum  input  72  four unsigned 18-bit block sums: s0=[17:0], s1=[35:18], s2=[53:36], s3=[71:54].
REQ-009 result  output  40  two's-complement reduced dot product.
REQ-010 result_valid  output  1  result is valid; held until result_ready.
REQ-011 result_ready  input  1  consumer accepts result.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 overrun  output  1  sticky error flag: sum_valid arrived when no pass was expected.

Function
REQ-014 The state machine SHALL have four states: IDLE, ACCUM, DRAIN, DONE.
REQ-015 IDLE -> ACCUM on start=1; at that edge:
- latch num_passes and signed_in;
- clear the accumulator and the pass counter p to 0.
REQ-016 In ACCUM, each sum_valid=1 cycle SHALL consume exactly one pass, increment p, and register:
- comb = s0 + (s1<<4) + (s2<<8) + (s3<<12), 31-bit unsigned;
- p;
- a last flag.
REQ-017 Pipeline stage 2 (the cycle after REQ-016) SHALL update the accumulator with comb<<p:
- acc -= comb<<p when the pass is last and signed_in=1;
- acc += comb<<p otherwise;
- arithmetic is 40-bit two's complement; shifts are zero-filled.
REQ-018 ACCUM -> DRAIN on the edge that consumes the last pass (p = N-1).
REQ-019 DRAIN -> DONE on the next edge, at which the final accumulate is applied.
REQ-020 Latency: result_valid SHALL be 1 exactly two cycles after the cycle carrying the last sum_valid.
REQ-021 sum_valid=0 in ACCUM SHALL stall: no pass is consumed and there is no timeout.
REQ-022 In DONE:
- result_valid=1 and result=acc, both held stable while result_ready=0;
- on result_ready=1 the block SHALL move to IDLE, and result_valid SHALL drop the next cycle.
REQ-023 start SHALL be ignored outside IDLE, including in a cycle where DONE completes via result_ready.
REQ-024 sum_valid=1 in IDLE, DRAIN or DONE SHALL be discarded, leave acc unchanged and set overrun=1.
REQ-025 overrun SHALL clear only on reset.
REQ-026 start=1 and sum_valid=1 in the same IDLE cycle: start is accepted, the sum is discarded, and overrun is set.
REQ-027 result SHALL be 0 whenever result_valid=0.
REQ-028 The unsigned worst case (8 passes, all sums 18'h3FFFF) is 292052205585 and SHALL NOT overflow 40 bits.

Reset
REQ-029 reset=1 SHALL force, at the next edge:
- state IDLE;
- acc, p, and the pipeline registers to 0;
- result=0, result_valid=0, busy=0, overrun=0.
REQ-030 reset SHALL take priority over every other input, including when asserted mid-ACCUM, DRAIN or DONE.
REQ-031 After reset, any in-flight pass SHALL be lost and the next start SHALL begin a clean operation.

Verification
REQ-032 Scenario: num_passes=1, signed_in=0, one pass s0=s1=s2=s3=1 -> result=4369 with result_valid two cycles after sum_valid.
REQ-033 Scenario: num_passes=2, signed_in=0, two passes with s0=3 and others 0 -> result=9.
REQ-034 Scenario: num_passes=2, signed_in=1, two passes with s0=1 -> result=40'hFF_FFFF_FFFF (-1).
REQ-035 Scenario: num_passes=0 (8 passes), all sums 18'h3FFFF, sum_valid gapped 1-on/1-off -> result=292052205585.
REQ-036 Scenario: result_ready held 0 for 5 cycles in DONE, then a stray sum_valid pulse -> result held stable and overrun=1; after result_ready=1 -> IDLE.
REQ-037 Scenario: reset asserted after pass 3 of 8 -> all outputs 0 next cycle; a new 1-pass start with s0=5 -> result=5.
